xup_dff_vector_arbiter: RTL

- Shares one SIZE-bit holding register among NREQ requesters.
- Round-robin arbitration, grant/release handshake, write-with-acknowledge.
- Instantiated where several datapath sources must load a single registered vector, e.g. shared display or LED value registers in XUP lab designs.
- The register is internal; its output q drives downstream logic directly.

---
 rtl/xup_dff_vector_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/xup_dff_vector_arbiter.sv
// Round-robin arbiter guarding one shared SIZE-bit register with grant/release and write-acknowledge.
// Optional forced release after TMAX owned cycles is compiled in when XUP_ARB_TIMEOUT_EN is defined.
module xup_dff_vector_arbiter #(
  parameter int SIZE  = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DELAY = 3,
  parameter int TMAX  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      rel,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*SIZE-1:0] d,
  output logic [NREQ-1:0]      gnt,
  output logic [IDW-1:0]       owner,
  output logic                 busy,
  output logic                 ack,
  output logic [SIZE-1:0]      q,
  output logic                 tout
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("xup_dff_vector_arbiter: NREQ must be in 2..8");
  end
  if ((1 << IDW) < NREQ) begin : g_bad_idw
    $error("xup_dff_vector_arbiter: IDW too narrow for NREQ");
  end
  if (TMAX < 1) begin : g_bad_tmax
    $error("xup_dff_vector_arbiter: TMAX must be at least 1");
  end

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            ack_q, ack_d;
  logic [SIZE-1:0] q_q, q_d;

  logic [IDW-1:0]  sel;
  logic            sel_vld;
  logic            own_we, own_rel, own_req;
  logic [SIZE-1:0] own_data;
  logic            release_now;

`ifdef XUP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
`endif

  // Scan last+1, last+2, ... ; descending k lets the nearest requester overwrite farther ones.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == (int'(last_q) + k) % NREQ)) begin
          sel     = IDW'(i);
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    own_we   = 1'b0;
    own_rel  = 1'b0;
    own_req  = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IDW'(i)) begin
        own_we   = we[i];
        own_rel  = rel[i];
        own_req  = req[i];
        own_data = d[i*SIZE +: SIZE];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    q_d         = q_q;
    ack_d       = 1'b0;
    release_now = 1'b0;
`ifdef XUP_ARB_TIMEOUT_EN
    tout_d      = 1'b0;
`endif
    if (state_q == IDLE) begin
      if (sel_vld) begin
        state_d = OWN;
        owner_d = sel;
        last_d  = sel;
        gnt_d   = NREQ'(1) << sel;
        busy_d  = 1'b1;
      end
    end else begin
      if (own_we) begin
        q_d   = own_data;
        ack_d = 1'b1;
      end
      release_now = own_rel | ~own_req;
`ifdef XUP_ARB_TIMEOUT_EN
      if (!release_now && cnt_q == CNT_W'(TMAX - 1)) begin
        release_now = 1'b1;
        tout_d      = 1'b1;
      end
`endif
      // Dropping the grant here forces the one-cycle gap before the next owner.
      if (release_now) begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= #DELAY IDLE;
      last_q  <= #DELAY IDW'(NREQ - 1);
      owner_q <= #DELAY '0;
      gnt_q   <= #DELAY '0;
      busy_q  <= #DELAY 1'b0;
      ack_q   <= #DELAY 1'b0;
      q_q     <= #DELAY '0;
    end else begin
      state_q <= #DELAY state_d;
      last_q  <= #DELAY last_d;
      owner_q <= #DELAY owner_d;
      gnt_q   <= #DELAY gnt_d;
      busy_q  <= #DELAY busy_d;
      ack_q   <= #DELAY ack_d;
      q_q     <= #DELAY q_d;
    end
  end

`ifdef XUP_ARB_TIMEOUT_EN
  // Held at zero while idle so every ownership starts counting from 0.
  always_comb begin
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= #DELAY '0;
      tout_q <= #DELAY 1'b0;
    end else begin
      cnt_q  <= #DELAY cnt_d;
      tout_q <= #DELAY tout_d;
    end
  end

  assign tout = tout_q;
`else
  assign tout = 1'b0;
`endif

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign q     = q_q;

endmodule
